// File: rtl/pic_ctrl_pkg.sv
// Shared types and constants for the PIC host-bus front end.
//   state_t   : initialisation sequencer states
//   *_SEL etc : bit positions decoded from the captured write word
package pic_ctrl_pkg;

    typedef enum logic [2:0] {
        UNINIT    = 3'd0,
        WAIT_ICW2 = 3'd1,
        WAIT_ICW3 = 3'd2,
        WAIT_ICW4 = 3'd3,
        READY     = 3'd4
    } state_t;

    localparam int ICW1_SEL = 4;   // A1=0 with this bit set is always ICW1
    localparam int OCW3_SEL = 3;   // A1=0, bit4=0: selects OCW3 over OCW2
    localparam int SNGL     = 1;   // ICW1: single (no cascade) mode
    localparam int IC4      = 0;   // ICW1: ICW4 will follow

endpackage

// File: rtl/pic_sync_edge.sv
// Synchroniser and edge detector for one active-low strobe qualified by
// an active-low chip select.
//   clk, reset          : core clock, synchronous active-high reset
//   i_cs_n, i_stb_n     : raw pins (active low)
//   o_level             : synchronised (~cs & ~stb)
//   o_rise / o_fall     : single-cycle pulses on level edges
module pic_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_cs_n,
    input  logic i_stb_n,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic w_cs_n;
    logic w_stb_n;
    logic r_prev;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_cs_n  = i_cs_n;
            assign w_stb_n = i_stb_n;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_cs_q;
            logic [SYNC_STAGES-1:0] r_stb_q;
            // Flops reset to the inactive (high) pin level so nothing is
            // seen as active while the chain refills.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cs_q  <= '1;
                    r_stb_q <= '1;
                end else begin
                    r_cs_q[0]  <= i_cs_n;
                    r_stb_q[0] <= i_stb_n;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_cs_q[i]  <= r_cs_q[i-1];
                        r_stb_q[i] <= r_stb_q[i-1];
                    end
                end
            end
            assign w_cs_n  = r_cs_q[SYNC_STAGES-1];
            assign w_stb_n = r_stb_q[SYNC_STAGES-1];
        end
    endgenerate

    assign o_level = ~w_cs_n & ~w_stb_n;

    always_ff @(posedge clk) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= o_level;
    end

    assign o_rise = o_level & ~r_prev;
    assign o_fall = ~o_level & r_prev;

endmodule

// File: rtl/pic_bus_ctrl_seq.sv
// Host-bus front end for the PIC core: synchronises the host pins, captures
// write data, commits each write on its trailing edge as one ICW/OCW pulse
// and tracks the ICW1->ICW2->[ICW3]->[ICW4] initialisation sequence.
//   clk, reset               : core clock, synchronous active-high reset
//   CS, rd_enable, wr_enable : host strobes (active low)
//   A1, bi_data_bus          : register select and write data
//   internal_bus             : last captured write word
//   write_ICW_1..4, OCW1..3  : single-cycle accept pulses
//   read, read_start         : read level (blocked during writes) and its start pulse
//   init_done                : sequencer is READY
//   single_mode, icw4_needed : SNGL / IC4 latched from ICW1
//   seq_err                  : ignored write, or RD/WR overlap entry
module pic_bus_ctrl_seq
    import pic_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  CS,
    input  logic                  rd_enable,
    input  logic                  wr_enable,
    input  logic                  A1,
    input  logic [DATA_WIDTH-1:0] bi_data_bus,
    output logic [DATA_WIDTH-1:0] internal_bus,
    output logic                  write_ICW_1,
    output logic                  write_ICW_2,
    output logic                  write_ICW_3,
    output logic                  write_ICW_4,
    output logic                  write_OCW1,
    output logic                  write_OCW2,
    output logic                  write_OCW3,
    output logic                  read,
    output logic                  read_start,
    output logic                  init_done,
    output logic                  single_mode,
    output logic                  icw4_needed,
    output logic                  seq_err
);

    logic                  w_wr_act, w_wr_rise, w_wr_fall;
    logic                  w_rd_act, w_rd_rise, w_rd_fall;
    logic [DATA_WIDTH-1:0] w_s_data;
    logic                  w_s_a1;
    logic                  w_read_rise;
    logic                  w_overlap_entry;
    logic                  r_a1;
    state_t                r_state;

    pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .clk(clk), .reset(reset), .i_cs_n(CS), .i_stb_n(wr_enable),
        .o_level(w_wr_act), .o_rise(w_wr_rise), .o_fall(w_wr_fall)
    );

    pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
        .clk(clk), .reset(reset), .i_cs_n(CS), .i_stb_n(rd_enable),
        .o_level(w_rd_act), .o_rise(w_rd_rise), .o_fall(w_rd_fall)
    );

    // A1 and data take the same number of stages as the strobes so the
    // captured word lines up with the synchronised write window.
    generate
        if (SYNC_STAGES == 0) begin : g_pay_bypass
            assign w_s_data = bi_data_bus;
            assign w_s_a1   = A1;
        end else begin : g_pay_sync
            logic [SYNC_STAGES-1:0][DATA_WIDTH:0] r_pay_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pay_q <= '0;
                end else begin
                    r_pay_q[0] <= {A1, bi_data_bus};
                    for (int i = 1; i < SYNC_STAGES; i++)
                        r_pay_q[i] <= r_pay_q[i-1];
                end
            end
            assign w_s_data = r_pay_q[SYNC_STAGES-1][DATA_WIDTH-1:0];
            assign w_s_a1   = r_pay_q[SYNC_STAGES-1][DATA_WIDTH];
        end
    endgenerate

    // read = rd_act & ~wr_act, expressed through edges so it can be kept
    // as a set/clear flop: it rises when RD starts outside a write or when
    // a write ends under an active RD.
    assign w_read_rise     = (w_rd_rise & ~w_wr_act) | (w_rd_act & w_wr_fall);
    assign w_overlap_entry = (w_wr_rise & w_rd_act) | (w_rd_rise & w_wr_act);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= UNINIT;
            r_a1         <= 1'b0;
            internal_bus <= '0;
            write_ICW_1  <= 1'b0;
            write_ICW_2  <= 1'b0;
            write_ICW_3  <= 1'b0;
            write_ICW_4  <= 1'b0;
            write_OCW1   <= 1'b0;
            write_OCW2   <= 1'b0;
            write_OCW3   <= 1'b0;
            read         <= 1'b0;
            read_start   <= 1'b0;
            init_done    <= 1'b0;
            single_mode  <= 1'b0;
            icw4_needed  <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            write_ICW_1 <= 1'b0;
            write_ICW_2 <= 1'b0;
            write_ICW_3 <= 1'b0;
            write_ICW_4 <= 1'b0;
            write_OCW1  <= 1'b0;
            write_OCW2  <= 1'b0;
            write_OCW3  <= 1'b0;
            seq_err     <= w_overlap_entry;
            read_start  <= w_read_rise;
            // Follows the state one clock later, so it rises the cycle after
            // the final ICW pulse; ICW1 below clears it immediately.
            init_done   <= (r_state == READY);

            if (w_read_rise)                          read <= 1'b1;
            else if (w_rd_fall | (w_wr_rise & w_rd_act)) read <= 1'b0;

            if (w_wr_act) begin
                internal_bus <= w_s_data;
                r_a1         <= w_s_a1;
            end

            // Trailing edge of the write window (WR or CS released).
            if (w_wr_fall) begin
                if (!r_a1 && internal_bus[ICW1_SEL]) begin
                    write_ICW_1 <= 1'b1;
                    single_mode <= internal_bus[SNGL];
                    icw4_needed <= internal_bus[IC4];
                    init_done   <= 1'b0;
                    r_state     <= WAIT_ICW2;
                end else if (!r_a1) begin
                    if (r_state == READY) begin
                        if (internal_bus[OCW3_SEL]) write_OCW3 <= 1'b1;
                        else                        write_OCW2 <= 1'b1;
                    end else begin
                        seq_err <= 1'b1;
                    end
                end else begin
                    case (r_state)
                        UNINIT: seq_err <= 1'b1;
                        WAIT_ICW2: begin
                            write_ICW_2 <= 1'b1;
                            if (!single_mode)     r_state <= WAIT_ICW3;
                            else if (icw4_needed) r_state <= WAIT_ICW4;
                            else                  r_state <= READY;
                        end
                        WAIT_ICW3: begin
                            write_ICW_3 <= 1'b1;
                            r_state     <= icw4_needed ? WAIT_ICW4 : READY;
                        end
                        WAIT_ICW4: begin
                            write_ICW_4 <= 1'b1;
                            r_state     <= READY;
                        end
                        READY:   write_OCW1 <= 1'b1;
                        default: r_state <= UNINIT;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pic_bus_ctrl_seq.sv
module tb_pic_bus_ctrl_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CS = 1'b1;
    logic       rd_enable = 1'b1;
    logic       wr_enable = 1'b1;
    logic       A1 = 1'b0;
    logic [7:0] bi_data_bus = 8'h00;

    logic [7:0] internal_bus;
    logic write_ICW_1, write_ICW_2, write_ICW_3, write_ICW_4;
    logic write_OCW1, write_OCW2, write_OCW3;
    logic read, read_start, init_done, single_mode, icw4_needed, seq_err;

    logic [7:0] z_internal_bus;
    logic z_write_ICW_1, z_write_ICW_2, z_write_ICW_3, z_write_ICW_4;
    logic z_write_OCW1, z_write_OCW2, z_write_OCW3;
    logic z_read, z_read_start, z_init_done, z_single_mode, z_icw4_needed, z_seq_err;

    pic_bus_ctrl_seq #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .CS(CS), .rd_enable(rd_enable), .wr_enable(wr_enable),
        .A1(A1), .bi_data_bus(bi_data_bus), .internal_bus(internal_bus),
        .write_ICW_1(write_ICW_1), .write_ICW_2(write_ICW_2), .write_ICW_3(write_ICW_3),
        .write_ICW_4(write_ICW_4), .write_OCW1(write_OCW1), .write_OCW2(write_OCW2),
        .write_OCW3(write_OCW3), .read(read), .read_start(read_start), .init_done(init_done),
        .single_mode(single_mode), .icw4_needed(icw4_needed), .seq_err(seq_err)
    );

    pic_bus_ctrl_seq #(.DATA_WIDTH(8), .SYNC_STAGES(0)) dut0 (
        .clk(clk), .reset(reset), .CS(CS), .rd_enable(rd_enable), .wr_enable(wr_enable),
        .A1(A1), .bi_data_bus(bi_data_bus), .internal_bus(z_internal_bus),
        .write_ICW_1(z_write_ICW_1), .write_ICW_2(z_write_ICW_2), .write_ICW_3(z_write_ICW_3),
        .write_ICW_4(z_write_ICW_4), .write_OCW1(z_write_OCW1), .write_OCW2(z_write_OCW2),
        .write_OCW3(z_write_OCW3), .read(z_read), .read_start(z_read_start),
        .init_done(z_init_done), .single_mode(z_single_mode), .icw4_needed(z_icw4_needed),
        .seq_err(z_seq_err)
    );

    always #5 clk = ~clk;

    // Pulse-count encoding: 2 bits per output, ordered as below.
    localparam logic [31:0] P_ICW1 = 32'h0000_0001;
    localparam logic [31:0] P_ICW2 = 32'h0000_0004;
    localparam logic [31:0] P_ICW3 = 32'h0000_0010;
    localparam logic [31:0] P_ICW4 = 32'h0000_0040;
    localparam logic [31:0] P_OCW1 = 32'h0000_0100;
    localparam logic [31:0] P_OCW2 = 32'h0000_0400;
    localparam logic [31:0] P_OCW3 = 32'h0000_1000;
    localparam logic [31:0] P_ERR  = 32'h0000_4000;
    localparam logic [31:0] P_RDS  = 32'h0001_0000;

    int total = 0;
    int bad = 0;
    int cnt [9] = '{default: 0};
    int base[9] = '{default: 0};

    // Count high cycles of each pulse output of the SYNC_STAGES=2 instance.
    always @(negedge clk) begin
        cnt[0] += int'(write_ICW_1);
        cnt[1] += int'(write_ICW_2);
        cnt[2] += int'(write_ICW_3);
        cnt[3] += int'(write_ICW_4);
        cnt[4] += int'(write_OCW1);
        cnt[5] += int'(write_OCW2);
        cnt[6] += int'(write_OCW3);
        cnt[7] += int'(seq_err);
        cnt[8] += int'(read_start);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        base = cnt;
    endtask

    function automatic logic [31:0] delta();
        logic [31:0] d;
        d = '0;
        for (int i = 0; i < 9; i++) d = d | (32'(cnt[i] - base[i]) << (2 * i));
        return d;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({internal_bus, write_ICW_1, write_ICW_2, write_ICW_3, write_ICW_4,
                    write_OCW1, write_OCW2, write_OCW3, read, read_start, init_done,
                    single_mode, icw4_needed, seq_err});
    endfunction

    task automatic wr(input logic a1, input logic [7:0] d, input string tag,
                      input logic [31:0] exp);
        snap();
        CS = 1'b0; wr_enable = 1'b0; A1 = a1; bi_data_bus = d;
        tick(2);
        CS = 1'b1; wr_enable = 1'b1;
        tick(6);
        chk(tag, delta(), exp);
    endtask

    int lat0, lat2;

    initial begin
        // Reset
        tick(3);
        chk("reset_outs", all_outs(), 32'h0);
        reset = 1'b0;
        tick(2);

        // 1: single mode with ICW4
        wr(1'b0, 8'h13, "t1_icw1", P_ICW1);
        chk("t1_sngl", 32'(single_mode), 32'h1);
        chk("t1_ic4", 32'(icw4_needed), 32'h1);
        wr(1'b1, 8'h20, "t1_icw2", P_ICW2);
        wr(1'b1, 8'h01, "t1_icw4", P_ICW4);
        chk("t1_init_done", 32'(init_done), 32'h1);

        // 2: cascade with ICW3 and ICW4, then OCW1
        wr(1'b0, 8'h11, "t2_icw1", P_ICW1);
        chk("t2_init_drop", 32'(init_done), 32'h0);
        chk("t2_sngl", 32'(single_mode), 32'h0);
        wr(1'b1, 8'h40, "t2_icw2", P_ICW2);
        wr(1'b1, 8'h04, "t2_icw3", P_ICW3);
        wr(1'b1, 8'h01, "t2_icw4", P_ICW4);
        chk("t2_init_done", 32'(init_done), 32'h1);
        wr(1'b1, 8'hFF, "t2_ocw1", P_OCW1);
        chk("t2_bus", 32'(internal_bus), 32'hFF);

        // 3: OCW2, OCW3, ICW1 restart
        wr(1'b0, 8'h20, "t3_ocw2", P_OCW2);
        wr(1'b0, 8'h0B, "t3_ocw3", P_OCW3);
        wr(1'b0, 8'h17, "t3_icw1", P_ICW1);
        chk("t3_init_drop", 32'(init_done), 32'h0);

        // 4: writes ignored in UNINIT, including after a mid-sequence reset
        reset = 1'b1;
        tick(2);
        chk("t4_reset_outs", all_outs(), 32'h0);
        reset = 1'b0;
        tick(1);
        wr(1'b1, 8'h55, "t4_uninit_err", P_ERR);
        wr(1'b0, 8'h11, "t4_icw1", P_ICW1);
        wr(1'b1, 8'h40, "t4_icw2", P_ICW2);
        reset = 1'b1;
        tick(2);
        chk("t4_midseq_reset_outs", all_outs(), 32'h0);
        reset = 1'b0;
        tick(1);
        wr(1'b1, 8'h33, "t4_after_reset_err", P_ERR);

        // 5: long write, data changing, one pulse, latency for both depths
        wr(1'b0, 8'h13, "t5_icw1", P_ICW1);
        snap();
        CS = 1'b0; wr_enable = 1'b0; A1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bi_data_bus = 8'h21 + 8'(i);
            tick(1);
        end
        CS = 1'b1; wr_enable = 1'b1;
        lat0 = 0; lat2 = 0;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            if (z_write_ICW_2 && lat0 == 0) lat0 = k;
            if (write_ICW_2 && lat2 == 0) lat2 = k;
        end
        chk("t5_one_pulse", delta(), P_ICW2);
        chk("t5_bus_last", 32'(internal_bus), 32'h25);
        chk("t5_bus_last_s0", 32'(z_internal_bus), 32'h25);
        chk("t5_latency_s0", 32'(lat0), 32'd1);
        chk("t5_latency_s2", 32'(lat2), 32'd3);
        wr(1'b1, 8'h01, "t5_icw4", P_ICW4);
        chk("t5_init_done", 32'(init_done), 32'h1);

        // Back-to-back writes with a one-cycle WR gap
        snap();
        CS = 1'b0; A1 = 1'b1; wr_enable = 1'b0; bi_data_bus = 8'h81;
        tick(2);
        wr_enable = 1'b1;
        tick(1);
        wr_enable = 1'b0; bi_data_bus = 8'h82;
        tick(2);
        CS = 1'b1; wr_enable = 1'b1;
        tick(6);
        chk("b2b_two_ocw1", delta(), 32'h0000_0200);
        chk("b2b_bus", 32'(internal_bus), 32'h82);

        // 6: RD/WR overlap, then RD alone
        snap();
        CS = 1'b0; rd_enable = 1'b0; wr_enable = 1'b0; A1 = 1'b1; bi_data_bus = 8'h5A;
        tick(4);
        chk("t6_read_blocked", 32'(read), 32'h0);
        CS = 1'b1; rd_enable = 1'b1; wr_enable = 1'b1;
        tick(6);
        chk("t6_overlap_pulses", delta(), P_OCW1 | P_ERR);
        chk("t6_bus", 32'(internal_bus), 32'h5A);

        snap();
        CS = 1'b0; rd_enable = 1'b0;
        tick(4);
        chk("t6_read_level", 32'(read), 32'h1);
        CS = 1'b1; rd_enable = 1'b1;
        tick(4);
        chk("t6_read_released", 32'(read), 32'h0);
        chk("t6_read_start", delta(), P_RDS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
